pipe_stage_hs: RTL

//  Parametrised pipeline-stage register with valid/ready handshake, flush and an optional 2-entry skid buffer.

---
 rtl/pipe_stage_hs_pkg.sv | 26 ++
 rtl/pipe_stage_hs_entry.sv | 26 ++
 rtl/pipe_stage_hs.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared occupancy encoding and next-state helper for the handshake pipeline stage.
package pipe_stage_hs_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Occupancy after one cycle of push/pop, ignoring flush.
   function automatic occ_e occ_next(input occ_e cur, input logic push, input logic pop);
      occ_e nxt;
      nxt = cur;
      case (cur)
         OCC_EMPTY: if (push) nxt = OCC_ONE;
         OCC_ONE: begin
            if (push && !pop)      nxt = OCC_TWO;
            else if (pop && !push) nxt = OCC_EMPTY;
         end
         OCC_TWO:   if (pop) nxt = OCC_ONE;
         default:   nxt = OCC_EMPTY;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pipe_stage_hs_entry.sv
// One stage slot: data register plus valid bit; load writes both, clear drops valid only.
// Latency 1 cycle; no flow control of its own (the owner decides load/clear).
module pipe_stage_hs_entry #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic              vld,
   output logic [DATA_W-1:0] dat
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= 1'b0;
         dat <= '0;
      end else begin
         if (load) dat <= d;
         if (clear)     vld <= 1'b0;
         else if (load) vld <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, flush, optional 2-entry skid and stall counter.
// Latency 1 cycle when empty; SKID=1 gives a registered in_ready, SKID=0 passes out_ready through.
module pipe_stage_hs
   import pipe_stage_hs_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   generate
      if (SKID != 0) begin : g_skid
         occ_e              state;
         occ_e              state_nxt;
         logic              push;
         logic              pop;
         logic              main_load;
         logic              main_clear;
         logic              main_sel_skid;
         logic              skid_load;
         logic              skid_clear;
         logic              main_vld;
         logic              skid_vld;
         logic [DATA_W-1:0] main_dat;
         logic [DATA_W-1:0] skid_dat;
         logic [DATA_W-1:0] main_d;

         assign in_ready  = (state != OCC_TWO);
         assign out_valid = main_vld;
         assign out_data  = main_dat;
         assign occupancy = state;
         assign push      = in_valid & in_ready;
         assign pop       = main_vld & out_ready;
         assign main_d    = main_sel_skid ? skid_dat : in_data;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) state <= OCC_EMPTY;
            else      state <= state_nxt;
         end

         // Flush overrides any handshake seen in the same cycle.
         always_comb begin
            state_nxt     = state;
            main_load     = 1'b0;
            main_clear    = 1'b0;
            main_sel_skid = 1'b0;
            skid_load     = 1'b0;
            skid_clear    = 1'b0;
            if (flush) begin
               state_nxt  = OCC_EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end else begin
               state_nxt = occ_next(state, push, pop);
               case (state)
                  OCC_EMPTY: main_load = push;
                  OCC_ONE: begin
                     main_load  = push & pop;
                     skid_load  = push & ~pop;
                     main_clear = pop & ~push;
                  end
                  OCC_TWO: begin
                     main_load     = pop;
                     main_sel_skid = pop;
                     skid_clear    = pop;
                  end
                  default: begin
                     main_clear = 1'b1;
                     skid_clear = 1'b1;
                  end
               endcase
            end
         end

         pipe_stage_hs_entry #(.DATA_W(DATA_W)) u_main (
            .clk   (clk),
            .rst   (rst),
            .load  (main_load),
            .clear (main_clear),
            .d     (main_d),
            .vld   (main_vld),
            .dat   (main_dat)
         );

         pipe_stage_hs_entry #(.DATA_W(DATA_W)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_data),
            .vld   (skid_vld),
            .dat   (skid_dat)
         );

         // Skid data only matters through main_d; its valid bit mirrors state TWO.
         logic skid_unused;
         assign skid_unused = skid_vld;
      end else begin : g_single
         logic              push;
         logic              pop;
         logic              main_vld;
         logic [DATA_W-1:0] main_dat;

         assign in_ready  = ~main_vld | out_ready;
         assign out_valid = main_vld;
         assign out_data  = main_dat;
         assign occupancy = {1'b0, main_vld};
         assign push      = in_valid & in_ready & ~flush;
         assign pop       = main_vld & out_ready & ~flush;

         pipe_stage_hs_entry #(.DATA_W(DATA_W)) u_main (
            .clk   (clk),
            .rst   (rst),
            .load  (push),
            .clear (flush | (pop & ~push)),
            .d     (in_data),
            .vld   (main_vld),
            .dat   (main_dat)
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
